// File: rtl/vga_box_painter.sv
// Pixel-colour stage: paints a 1-px screen frame and a bouncing outlined box.
// Latency: rgb/hsync/vsync appear exactly 2 ticks after the matching inputs.
// Backpressure: none; every register advances only on tick and holds otherwise.
module vga_box_painter #(
  parameter int          HD         = 640,
  parameter int          VD         = 480,
  parameter int          BOX_SIZE   = 32,
  parameter int          BOX_STEP   = 2,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] BOX_COLOR  = 12'hF00,
  parameter logic [11:0] EDGE_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixelx,
  input  logic [9:0]  pixely,
  input  logic        move_en,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  // Per-axis direction states; "increasing" is encoded as 0 on both axes.
  localparam logic [0:0] DIR_RIGHT = 1'b0;
  localparam logic [0:0] DIR_LEFT  = 1'b1;
  localparam logic [0:0] DIR_DOWN  = 1'b0;
  localparam logic [0:0] DIR_UP    = 1'b1;

  // Position arithmetic is 11 bits wide so pos+STEP can never wrap.
  localparam logic [10:0] LX      = 11'(HD - BOX_SIZE);
  localparam logic [10:0] LY      = 11'(VD - BOX_SIZE);
  localparam logic [10:0] STEP    = 11'(BOX_STEP);
  localparam logic [10:0] SIZE_M1 = 11'(BOX_SIZE - 1);
  localparam logic [9:0]  X0      = 10'((HD - BOX_SIZE) / 2);
  localparam logic [9:0]  Y0      = 10'((VD - BOX_SIZE) / 2);
  localparam logic [9:0]  X_LAST  = 10'(HD - 1);
  localparam logic [9:0]  Y_LAST  = 10'(VD - 1);
  localparam logic [9:0]  Y_EVENT = 10'(VD);

  logic [9:0] s1_x, s1_y;
  logic       s1_von, s1_hs, s1_vs;
  logic [0:0] dir_x, dir_y;

  logic [10:0] x11, y11, bx11, by11, bx_end, by_end;
  logic        in_box, on_outline, on_frame, frame_event;
  logic [11:0] pix_color;
  logic [10:0] step_x, step_y;

  // One axis step: returns {next_dir, next_pos}. Direction flips when the
  // clamped result lands exactly on the limit (increasing) or on 0 (decreasing).
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] n;
    logic        d;
    p = {1'b0, pos};
    if (dir == 1'b0) begin
      n = p + STEP;
      if (n >= lim) n = lim;
      d = (n == lim);
    end else begin
      n = (p < STEP) ? 11'd0 : p - STEP;
      d = (n != 11'd0);
    end
    return {d, 10'(n)};
  endfunction

  assign x11    = {1'b0, s1_x};
  assign y11    = {1'b0, s1_y};
  assign bx11   = {1'b0, box_x};
  assign by11   = {1'b0, box_y};
  assign bx_end = bx11 + SIZE_M1;
  assign by_end = by11 + SIZE_M1;

  assign in_box     = (x11 >= bx11) && (x11 <= bx_end) && (y11 >= by11) && (y11 <= by_end);
  assign on_outline = (x11 == bx11) || (x11 == bx_end) || (y11 == by11) || (y11 == by_end);
  assign on_frame   = (s1_x == 10'd0) || (s1_x == X_LAST) || (s1_y == 10'd0) || (s1_y == Y_LAST);

  // Box moves once per frame, in vertical blanking, seen on the input side.
  assign frame_event = tick && move_en && (pixelx == 10'd0) && (pixely == Y_EVENT);

  assign step_x = step_axis(box_x, dir_x[0], LX);
  assign step_y = step_axis(box_y, dir_y[0], LY);

  // Colour selection from stage-1 pixel; box outranks the screen frame.
  always_comb begin
    pix_color = BG_COLOR;
    if (!s1_von)
      pix_color = 12'h000;
    else if (in_box)
      pix_color = on_outline ? EDGE_COLOR : BOX_COLOR;
    else if (on_frame)
      pix_color = EDGE_COLOR;
  end

  // Two-stage pixel pipeline: S1 captures inputs, S2 drives rgb and syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_x   <= 10'd0;
      s1_y   <= 10'd0;
      s1_von <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      rgb    <= 12'h000;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (tick) begin
      s1_x   <= pixelx;
      s1_y   <= pixely;
      s1_von <= video_on;
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
      rgb    <= pix_color;
      hsync  <= s1_hs;
      vsync  <= s1_vs;
    end
  end

  // Box position and per-axis bounce direction, updated on the frame event.
  always_ff @(posedge clk) begin
    if (reset) begin
      box_x <= X0;
      box_y <= Y0;
      dir_x <= DIR_RIGHT;
      dir_y <= DIR_DOWN;
    end else if (frame_event) begin
      box_x <= step_x[9:0];
      box_y <= step_y[9:0];
      dir_x <= step_x[10] ? DIR_LEFT : DIR_RIGHT;
      dir_y <= step_y[10] ? DIR_UP : DIR_DOWN;
    end
  end

endmodule

// File: tb/tb_vga_box_painter.sv
// Directed bench for vga_box_painter: pipeline timing, colours, tick gating,
// frame-event movement, bouncing and mid-frame reset. A second instance with a
// square screen makes both axes reach their limits on the same frame event.
module tb_vga_box_painter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        video_on = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [9:0]  pixelx = 10'd0;
  logic [9:0]  pixely = 10'd0;
  logic        move_en = 1'b0;
  logic [11:0] rgb, rgb2;
  logic        hsync, vsync, hsync2, vsync2;
  logic [9:0]  box_x, box_y, box_x2, box_y2;

  int checks = 0;
  int errors = 0;

  vga_box_painter dut (
    .clk(clk), .reset(reset), .tick(tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixelx(pixelx), .pixely(pixely),
    .move_en(move_en), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .box_x(box_x), .box_y(box_y)
  );

  // Square 480x480 screen: limits 448/448 from centre 224/224, so a corner hit
  // happens after 112 events.
  vga_box_painter #(.HD(480), .VD(480)) dut_sq (
    .clk(clk), .reset(reset), .tick(tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixelx(pixelx), .pixely(pixely),
    .move_en(move_en), .rgb(rgb2), .hsync(hsync2), .vsync(vsync2),
    .box_x(box_x2), .box_y(box_y2)
  );

  always #5 clk = ~clk;

  // Colour table around the centred box (304..335, 224..255).
  logic [9:0]  t2_x   [11] = '{10'd320, 10'd304, 10'd335, 10'd336, 10'd320, 10'd320,
                               10'd320, 10'd100, 10'd639, 10'd100, 10'd320};
  logic [9:0]  t2_y   [11] = '{10'd240, 10'd240, 10'd240, 10'd240, 10'd255, 10'd224,
                               10'd223, 10'd100, 10'd100, 10'd479, 10'd240};
  logic        t2_von [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        t2_hs  [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        t2_vs  [11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [11:0] t2_rgb [11] = '{12'hF00, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF,
                               12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h000};

  task automatic set_px(input logic [9:0] x, input logic [9:0] y, input logic von,
                        input logic hs, input logic vs);
    pixelx   = x;
    pixely   = y;
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  // One tick pulse, then three idle clocks (tick every 4 clk).
  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_event();
    set_px(10'd0, 10'd480, 1'b0, 1'b0, 1'b1);
    do_tick();
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want %h", rgb, 12'h000); end
    checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b%b want 00", hsync, vsync); end
    checks++; if (box_x !== 10'd304) begin errors++; $display("FAIL reset_box_x: got %0d want 304", box_x); end
    checks++; if (box_y !== 10'd224) begin errors++; $display("FAIL reset_box_y: got %0d want 224", box_y); end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    set_px(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
    do_tick();
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_rgb_t1: got %h want %h", rgb, 12'h000); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL lat_hsync_t1: got %b want 0", hsync); end
    do_tick();
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL lat_rgb_t2: got %h want %h", rgb, 12'hFFF); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL lat_hsync_t2: got %b want 1", hsync); end
  endtask

  task automatic test_colours();
    for (int i = 0; i < 11; i++) begin
      set_px(t2_x[i], t2_y[i], t2_von[i], t2_hs[i], t2_vs[i]);
      do_tick();
      do_tick();
      checks++; if (rgb !== t2_rgb[i]) begin errors++; $display("FAIL colour_%0d (x=%0d y=%0d): got %h want %h", i, t2_x[i], t2_y[i], rgb, t2_rgb[i]); end
      checks++; if (hsync !== t2_hs[i] || vsync !== t2_vs[i]) begin errors++; $display("FAIL colour_sync_%0d: got %b%b want %b%b", i, hsync, vsync, t2_hs[i], t2_vs[i]); end
    end
  endtask

  // Last colour entry left rgb=000, hsync=1, vsync=1; nothing may move without tick.
  task automatic test_tick_hold();
    move_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 3 == 0) set_px(10'd0, 10'd480, 1'b1, 1'b0, 1'b0);
      else set_px(10'($urandom_range(639)), 10'($urandom_range(479)), 1'b1, 1'($urandom_range(1)), 1'b0);
      @(negedge clk);
      checks++; if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL hold_out_%0d: got %h %b%b want 000 11", i, rgb, hsync, vsync); end
      checks++; if (box_x !== 10'd304 || box_y !== 10'd224) begin errors++; $display("FAIL hold_box_%0d: got %0d,%0d want 304,224", i, box_x, box_y); end
    end
  endtask

  task automatic test_move();
    move_en = 1'b1;
    frame_event();
    checks++; if (box_x !== 10'd306 || box_y !== 10'd226) begin errors++; $display("FAIL move_event: got %0d,%0d want 306,226", box_x, box_y); end
    set_px(10'd1, 10'd480, 1'b0, 1'b0, 1'b1);
    do_tick();
    checks++; if (box_x !== 10'd306 || box_y !== 10'd226) begin errors++; $display("FAIL move_x1: got %0d,%0d want 306,226", box_x, box_y); end
    move_en = 1'b0;
    frame_event();
    checks++; if (box_x !== 10'd306 || box_y !== 10'd226) begin errors++; $display("FAIL move_frozen: got %0d,%0d want 306,226", box_x, box_y); end
  endtask

  // Tick every clock; box sits at (306,226) so 320,240 is interior, 306,240 outline.
  task automatic test_back_to_back();
    logic [9:0]  bx [6] = '{10'd0, 10'd100, 10'd639, 10'd320, 10'd306, 10'd100};
    logic [9:0]  by [6] = '{10'd0, 10'd100, 10'd100, 10'd240, 10'd240, 10'd100};
    logic [11:0] be [6] = '{12'hFFF, 12'h000, 12'hFFF, 12'hF00, 12'hFFF, 12'h000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++; if (rgb !== be[i-2]) begin errors++; $display("FAIL b2b_rgb_%0d: got %h want %h", i - 2, rgb, be[i-2]); end
        checks++; if (hsync !== 1'((i - 2) % 2)) begin errors++; $display("FAIL b2b_hsync_%0d: got %b want %b", i - 2, hsync, 1'((i - 2) % 2)); end
      end
      if (i < 6) set_px(bx[i], by[i], 1'b1, 1'(i % 2), 1'b0);
      tick = 1'b1;
    end
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic test_bounce();
    do_reset();
    move_en = 1'b1;
    repeat (112) frame_event();
    checks++; if (box_x !== 10'd528 || box_y !== 10'd448) begin errors++; $display("FAIL bounce_y_limit: got %0d,%0d want 528,448", box_x, box_y); end
    checks++; if (box_x2 !== 10'd448 || box_y2 !== 10'd448) begin errors++; $display("FAIL corner_limit: got %0d,%0d want 448,448", box_x2, box_y2); end
    frame_event();
    checks++; if (box_x !== 10'd530 || box_y !== 10'd446) begin errors++; $display("FAIL bounce_y_flip: got %0d,%0d want 530,446", box_x, box_y); end
    checks++; if (box_x2 !== 10'd446 || box_y2 !== 10'd446) begin errors++; $display("FAIL corner_flip: got %0d,%0d want 446,446", box_x2, box_y2); end
    repeat (39) frame_event();
    checks++; if (box_x !== 10'd608 || box_y !== 10'd368) begin errors++; $display("FAIL bounce_x_limit: got %0d,%0d want 608,368", box_x, box_y); end
    frame_event();
    checks++; if (box_x !== 10'd606 || box_y !== 10'd366) begin errors++; $display("FAIL bounce_x_flip: got %0d,%0d want 606,366", box_x, box_y); end
    checks++; if (box_x2 !== 10'd366 || box_y2 !== 10'd366) begin errors++; $display("FAIL corner_after: got %0d,%0d want 366,366", box_x2, box_y2); end
  endtask

  task automatic test_mid_frame_reset();
    set_px(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    do_tick();
    do_tick();
    checks++; if (rgb !== 12'hFFF || hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL pre_reset: got %h %b%b want fff 11", rgb, hsync, vsync); end
    @(negedge clk) begin reset = 1'b1; tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; tick = 1'b0; end
    checks++; if (rgb !== 12'h000 || hsync !== 1'b0 || vsync !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %h %b%b want 000 00", rgb, hsync, vsync); end
    checks++; if (box_x !== 10'd304 || box_y !== 10'd224) begin errors++; $display("FAIL mid_reset_box: got %0d,%0d want 304,224", box_x, box_y); end
    set_px(10'd320, 10'd240, 1'b1, 1'b1, 1'b0);
    do_tick();
    checks++; if (rgb !== 12'h000 || hsync !== 1'b0) begin errors++; $display("FAIL post_reset_t1: got %h %b want 000 0", rgb, hsync); end
    do_tick();
    checks++; if (rgb !== 12'hF00 || hsync !== 1'b1) begin errors++; $display("FAIL post_reset_t2: got %h %b want f00 1", rgb, hsync); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_colours();
    test_tick_hold();
    test_move();
    test_back_to_back();
    test_bounce();
    test_mid_frame_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
